// File: rtl/req_tracker_pkg.sv
// Shared definitions for the request tracker: FSM state encoding and parameter defaults.
package req_tracker_pkg;

    localparam int N_DEFAULT         = 8;
    localparam int CNT_W_DEFAULT     = 3;
    localparam int AGE_LIMIT_DEFAULT = 15;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } state_t;

endpackage

// File: rtl/req_slot.sv
// One source's pending counter, age counter and served pulse.
module req_slot #(
    parameter int CNT_W     = 3,
    parameter int AGE_LIMIT = 15
) (
    input  logic clock,
    input  logic reset,
    input  logic accept_ok,
    input  logic src_valid,
    input  logic en,
    input  logic gnt,
    output logic src_ready,
    output logic req,
    output logic accepted,
    output logic src_done,
    output logic starve,
    output logic idle_next
);

    localparam int AGE_W = $clog2(AGE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(AGE_LIMIT);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AGE_W-1:0] age_q, age_d;
    logic             done_q;
    logic             consume;

    assign src_ready = (cnt_q != CNT_MAX) & accept_ok;
    assign req       = (cnt_q != '0);
    assign accepted  = src_valid & src_ready;
    assign consume   = en & gnt & req;
    assign idle_next = (cnt_d == '0);
    assign starve    = (age_q == AGE_MAX);
    assign src_done  = done_q;

    always_comb begin
        cnt_d = cnt_q;
        if (accepted && !consume) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!accepted && consume) begin
            cnt_d = cnt_q - CNT_W'(1);
        end

        // Age restarts whenever the source is served or empties out.
        age_d = age_q;
        if (consume || (cnt_d == '0)) begin
            age_d = '0;
        end else if (req && (age_q != AGE_MAX)) begin
            age_d = age_q + AGE_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q  <= '0;
            age_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            age_q  <= age_d;
            done_q <= consume;
        end
    end

endmodule

// File: rtl/req_tracker.sv
// Tracks pending requests of N sources towards an external priority selector,
// with starvation flags, a flush/drain sequence and a sticky protocol-error flag.
module req_tracker
    import req_tracker_pkg::*;
#(
    parameter int N         = N_DEFAULT,
    parameter int CNT_W     = CNT_W_DEFAULT,
    parameter int AGE_LIMIT = AGE_LIMIT_DEFAULT
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [N-1:0] src_valid,
    output logic [N-1:0] src_ready,
    input  logic         flush,
    input  logic         stall,
    output logic [N-1:0] req,
    output logic         en,
    input  logic [N-1:0] gnt,
    output logic [N-1:0] src_done,
    output logic [N-1:0] starve,
    output logic         flush_done,
    output logic         err,
    output state_t       state
);

    // Handshake: a source request is taken on a cycle where src_valid[i] and
    // src_ready[i] are both high; valid without ready is simply dropped.

    state_t       state_q, state_d;
    logic         err_q, err_d;
    logic         flush_done_q, flush_done_d;
    logic [N-1:0] accepted;
    logic [N-1:0] idle_next;
    logic         all_idle;
    logic         accept_ok;
    logic         multi_gnt;
    logic         orphan_gnt;

    assign en        = ~stall;
    assign accept_ok = (state_q != DRAIN);
    assign all_idle  = &idle_next;
    assign state     = state_q;
    assign err       = err_q;
    assign flush_done = flush_done_q;

    for (genvar i = 0; i < N; i++) begin : g_slot
        req_slot #(
            .CNT_W     (CNT_W),
            .AGE_LIMIT (AGE_LIMIT)
        ) u_slot (
            .clock     (clock),
            .reset     (reset),
            .accept_ok (accept_ok),
            .src_valid (src_valid[i]),
            .en        (en),
            .gnt       (gnt[i]),
            .src_ready (src_ready[i]),
            .req       (req[i]),
            .accepted  (accepted[i]),
            .src_done  (src_done[i]),
            .starve    (starve[i]),
            .idle_next (idle_next[i])
        );
    end

    assign multi_gnt  = ((gnt & (gnt - N'(1))) != '0);
    assign orphan_gnt = en & (|(gnt & ~req));

    always_comb begin
        state_d      = state_q;
        flush_done_d = 1'b0;
        err_d        = err_q | multi_gnt | orphan_gnt;
        case (state_q)
            IDLE: begin
                if (flush) begin
                    state_d = DRAIN;
                end else if (|accepted) begin
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (flush) begin
                    state_d = DRAIN;
                end else if (all_idle) begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                if (all_idle) begin
                    state_d      = IDLE;
                    flush_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            err_q        <= 1'b0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            err_q        <= err_d;
            flush_done_q <= flush_done_d;
        end
    end

endmodule

// File: doc/req_tracker.md
REQ_TRACKER -- requirements
Module: req_tracker

Interface
REQ-001 SHALL have parameters (name, default, meaning): N, 8, number of requesting sources; CNT_W, 3, pending-counter width; AGE_LIMIT, 15, wait cycles before the starve flag is set.
REQ-002 clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 src_valid  input  N  per-source request pulse, one request per asserted cycle.
REQ-005 src_ready  output  N  source i may issue a request this cycle.
REQ-006 flush  input  1  start drain: stop accepting, grant out all pending requests.
REQ-007 stall  input  1  hold the arbiter: no grants consumed.
REQ-008 req  output  N  request vector to the downstream priority selector.
REQ-009 en  output  1  enable to the selector; equals ~stall.
REQ-010 gnt  input  N  grant vector from the selector; one-hot or zero.
REQ-011 src_done  output  N  one-cycle pulse: one request of source i was served.
REQ-012 starve  output  N  source i has waited AGE_LIMIT or more cycles.
REQ-013 flush_done  output  1  one-cycle pulse: drain complete.
REQ-014 err  output  1  sticky protocol-error flag.

Function
REQ-015 Per source, SHALL keep a CNT_W-bit pending count cnt[i], range 0..2^CNT_W-1.
REQ-016 src_ready[i] = (cnt[i] != max) & (state != DRAIN), combinational from registered state.
REQ-017 accept[i] = src_valid[i] & src_ready[i]; src_valid while not ready SHALL be dropped with cnt unchanged and no error.
REQ-018 req[i] = (cnt[i] != 0), driven from registers only; a request accepted in cycle t appears on req in cycle t+1.
REQ-019 consume[i] = en & gnt[i] & req[i]; each consume SHALL decrement cnt[i] by one.
REQ-020 accept and consume of the same source in the same cycle SHALL leave cnt[i] unchanged.
REQ-021 src_done[i] SHALL be registered: high in cycle t+1 for a consume in cycle t.
REQ-022 err SHALL set and stay set (until reset) when gnt has more than one bit high, or when gnt[i] & ~req[i] while en=1; a gnt bit with no matching req SHALL not change cnt.
REQ-023 Per-source age counter: +1 per cycle while req[i] & ~consume[i]; cleared on consume[i] or when cnt[i] becomes 0; saturates at AGE_LIMIT.
REQ-024 starve[i] = (age[i] == AGE_LIMIT), registered.
REQ-025 FSM states: IDLE, ACTIVE, DRAIN.
REQ-026 IDLE -> ACTIVE when any accept occurs; IDLE -> DRAIN on flush (DRAIN exits on the next cycle, since all cnt are 0).
REQ-027 ACTIVE -> IDLE when the next-cycle value of every cnt is 0; ACTIVE -> DRAIN on flush (flush takes precedence).
REQ-028 DRAIN: no accepts; grants are consumed normally; DRAIN -> IDLE when the next-cycle value of every cnt is 0, with flush_done pulsed in the first IDLE cycle.
REQ-029 flush asserted while in DRAIN SHALL be ignored.
REQ-030 stall=1 SHALL freeze consumes; accepts and aging continue.

Reset
REQ-031 On reset=1 at a clock edge, SHALL clear all cnt, ages, src_done, starve, flush_done and err, and enter IDLE; reset takes precedence over every other input.
REQ-032 Reset mid-drain or mid-operation SHALL discard pending requests silently, with no src_done or flush_done pulses.
REQ-033 Outputs in the cycle after reset: req=0, src_ready=all 1s, src_done=0, starve=0, flush_done=0, err=0; en=~stall.

Structure
REQ-034 A shared package SHALL hold the FSM state enum (IDLE, ACTIVE, DRAIN) and the N / CNT_W / AGE_LIMIT defaults.
REQ-035 One sub-module, req_slot, SHALL implement one source's counter and age logic, instantiated N times.
REQ-036 The FSM and err logic SHALL live in the top module; the priority selector is external.

Verification
REQ-037 Single request: src_valid=8'h04 for 1 cycle, gnt=8'h04 next cycle -> req=8'h04 for one cycle, src_done=8'h04 one cycle later, state back to IDLE.
REQ-038 Saturation: 9 consecutive pulses on source 0 with gnt=0 -> cnt[0]=7, src_ready[0]=0 after the 7th, 8th and 9th pulses dropped, err=0.
REQ-039 Simultaneous events: cnt[3]=2, accept and consume on source 3 in the same cycle -> cnt[3] stays 2, src_done[3] pulses.
REQ-040 Starvation: req[5] held with gnt=0 for 15 cycles -> starve[5]=1; one grant on source 5 -> starve[5]=0 next cycle.
REQ-041 Drain: sources 1 and 6 each with 2 pending, then flush -> src_ready=0; after 4 grants, flush_done pulses once and state is IDLE.
REQ-042 Errors and reset: gnt=8'h03 -> err=1 and stays set; reset mid-drain -> err=0, req=0, no flush_done pulse.
